core_mc_seq: RTL

Multi-cycle sequencer for the next-generation core. It owns the PC and instruction register and steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB over a single shared instruction/data memory port with a req/ready handshake. It gates register write-back, stops on halt, and keeps performance counters. The existing decoder, controller, ALU, JB unit, immediate extender, load filter and register file attach to it unchanged.

---
 rtl/core_mc_seq_pkg.sv | 20 ++
 rtl/core_mc_seq_if.sv | 33 +++
 rtl/core_mc_seq_wait_timer.sv | 37 +++
 rtl/core_mc_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/core_mc_seq_pkg.sv
// Shared definitions for the multi-cycle core sequencer: FSM state encoding,
// the reset instruction and the sequential PC step.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/core_mc_seq_if.sv
// Shared instruction/data memory port. The sequencer is the master and owns
// the request side; the memory answers with read data and a ready strobe.
interface core_mc_seq_if #(
    parameter int ADDR_W = 16,
    parameter int XLEN   = 32
);

    logic              mem_req;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/core_mc_seq_wait_timer.sv
// Counts stalled memory cycles of the current transaction and flags the
// cycle in which the stall count would reach MAX_WAIT.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: zero while no transaction is open, +1 per stalled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Stall counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = count && !clear && (cnt_q == 16'(MAX_WAIT - 1));

endmodule

// File: rtl/core_mc_seq.sv
// Multi-cycle sequencer: owns PC and IR, walks each instruction through
// FETCH/DECODE/EXEC/(MEM)/WB over one shared memory port, gates register
// write-back and keeps cycle/retired-instruction counters.
module core_mc_seq
    import core_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          XLEN     = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned MAX_WAIT = 255,
    parameter int          CNT_W    = 32
) (
    input  logic              sysclk,
    input  logic              sysrst,
    core_mc_seq_if.master     mbus,
    input  logic              next_pc_sel,
    input  logic              wb_en,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              is_halt,
    input  logic [3:0]        dm_w_en,
    input  logic [XLEN-1:0]   jb_pc,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   rs2_data,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [XLEN-1:0]   ld_data,
    output logic [XLEN-1:0]   alu_r,
    output logic              rf_wb_en,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret
);

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [31:0]       ir_q,      ir_d;
    logic [XLEN-1:0]   alu_r_q,   alu_r_d;
    logic [XLEN-1:0]   ld_data_q, ld_data_d;
    logic [CNT_W-1:0]  cycle_q,   cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic              req;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic              timeout;
    logic              misaligned;
    logic              unused_jb_bits;

    // Jump targets only use the address bits; bit 0 is always forced to 0.
    assign unused_jb_bits = ^{jb_pc[XLEN-1:ADDR_W], jb_pc[0]};
    assign misaligned     = next_pc_sel && jb_pc[1];

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (sysclk),
        .rst_n   (sysrst),
        .clear   (!req),
        .count   (req && !mbus.mem_ready),
        .timeout (timeout)
    );

    // Memory port and write-back strobe decoded from registered state only.
    always_comb begin
        req      = 1'b0;
        we       = 4'h0;
        addr     = '0;
        wdata    = '0;
        rf_wb_en = 1'b0;
        case (state_q)
            ST_FETCH: begin
                req  = 1'b1;
                addr = pc_q;
            end
            ST_MEM: begin
                req  = 1'b1;
                addr = alu_r_q[ADDR_W-1:0];
                if (is_store) begin
                    we    = dm_w_en;
                    wdata = rs2_data;
                end
            end
            ST_WB: begin
                rf_wb_en = wb_en && !is_store;
            end
            default: begin
            end
        endcase
    end

    // Next-state, PC and latch updates for each pipeline step.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_r_d   = alu_r_q;
        ld_data_d = ld_data_q;
        instret_d = instret_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mbus.mem_ready) begin
                    ir_d    = mbus.mem_rdata[31:0];
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_r_d = alu_out;
                if (is_halt) begin
                    state_d = ST_HALT;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mbus.mem_ready) begin
                    if (is_load) begin
                        ld_data_d = mbus.mem_rdata;
                    end
                    state_d = ST_WB;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                if (misaligned) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_d      = next_pc_sel ? {jb_pc[ADDR_W-1:1], 1'b0}
                                            : pc_q + ADDR_W'(PC_INC);
                    instret_d = instret_q + CNT_W'(1);
                    state_d   = ST_FETCH;
                end
            end
            default: begin
            end
        endcase
    end

    // The cycle counter runs in every live state and freezes once terminal.
    always_comb begin
        cycle_d = cycle_q;
        if (state_q != ST_HALT && state_q != ST_FAULT) begin
            cycle_d = cycle_q + CNT_W'(1);
        end
    end

    // Architectural state registers with synchronous active-low reset.
    always_ff @(posedge sysclk) begin
        if (!sysrst) begin
            state_q   <= ST_IDLE;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= NOP_INST;
            alu_r_q   <= '0;
            ld_data_q <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_r_q   <= alu_r_d;
            ld_data_q <= ld_data_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign mbus.mem_req   = req;
    assign mbus.mem_we    = we;
    assign mbus.mem_addr  = addr;
    assign mbus.mem_wdata = wdata;

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign alu_r     = alu_r_q;
    assign ld_data   = ld_data_q;
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT);
    assign fault     = (state_q == ST_FAULT);
    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;

endmodule
